writeback_arbiter: RTL and testbench

- Write-side initiator for the 32-entry register file: merges two result producers into the register file's single write port (reg_write/waddr/wdata).
- Port A is the single-cycle ALU/load path. It has priority and no backpressure.
- Port B is the multi-cycle unit path (e.g. multiplier). It uses valid/ready and is buffered in a DEPTH-entry FIFO.
- Enforces write-after-write order (a younger A write squashes older pending B writes to the same register) and exposes pending-write flags so decode can stall.

---
 rtl/writeback_arbiter_pkg.sv | 8 +
 rtl/writeback_arbiter_if.sv | 29 ++
 rtl/writeback_arbiter_wb_fifo.sv | 67 ++++++
 rtl/writeback_arbiter.sv | 62 ++++++
 tb/tb_writeback_arbiter.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/writeback_arbiter_pkg.sv
// writeback_arbiter_pkg: register file geometry shared by the writeback path
package writeback_arbiter_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int N_REG = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam int DEF_DATA_W = 16;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: producer ports, register file write port and pending query
interface writeback_arbiter_if import writeback_arbiter_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH = 4
) ();
   logic a_valid;
   reg_addr_t a_waddr;
   logic [DATA_W-1:0] a_wdata;
   logic b_valid;
   logic b_ready;
   reg_addr_t b_waddr;
   logic [DATA_W-1:0] b_wdata;
   logic reg_write;
   reg_addr_t waddr;
   logic [DATA_W-1:0] wdata;
   reg_addr_t pend_raddr_1;
   reg_addr_t pend_raddr_2;
   logic pend_1;
   logic pend_2;
   logic [$clog2(DEPTH):0] fifo_level;
   modport master (
      output a_valid, a_waddr, a_wdata, b_valid, b_waddr, b_wdata, pend_raddr_1, pend_raddr_2,
      input b_ready, reg_write, waddr, wdata, pend_1, pend_2, fifo_level
   );
   modport slave (
      input a_valid, a_waddr, a_wdata, b_valid, b_waddr, b_wdata, pend_raddr_1, pend_raddr_2,
      output b_ready, reg_write, waddr, wdata, pend_1, pend_2, fifo_level
   );
endinterface

// File: rtl/writeback_arbiter_wb_fifo.sv
// wb_fifo: B-path write buffer with per-entry valid bits, squash-by-address and address match
module wb_fifo import writeback_arbiter_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH = 4
) (
   input logic clk,
   input logic arst_n,
   input logic push,
   input logic push_valid,
   input reg_addr_t push_addr,
   input logic [DATA_W-1:0] push_data,
   input logic pop,
   input logic squash,
   input reg_addr_t squash_addr,
   input reg_addr_t query_1,
   input reg_addr_t query_2,
   output logic head_valid,
   output reg_addr_t head_addr,
   output logic [DATA_W-1:0] head_data,
   output logic match_1,
   output logic match_2,
   output logic [$clog2(DEPTH):0] level,
   output logic full
);
   localparam int PW = $clog2(DEPTH);
   logic [DEPTH-1:0] valid;
   reg_addr_t addr [DEPTH];
   logic [DATA_W-1:0] data [DEPTH];
   logic [PW-1:0] rptr, wptr;
   // valid bits are cleared on pop so only occupied entries can ever match
   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) begin
         valid <= '0;
         rptr <= '0;
         wptr <= '0;
         level <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (squash && addr[i] == squash_addr) valid[i] <= 1'b0;
         if (pop) begin
            valid[rptr] <= 1'b0;
            rptr <= rptr + 1'b1;
         end
         if (push) begin
            valid[wptr] <= push_valid;
            wptr <= wptr + 1'b1;
         end
         level <= level + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
   always_ff @(posedge clk)
      if (push) begin
         addr[wptr] <= push_addr;
         data[wptr] <= push_data;
      end
   always_comb begin
      match_1 = 1'b0;
      match_2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         match_1 = match_1 | (valid[i] && addr[i] == query_1);
         match_2 = match_2 | (valid[i] && addr[i] == query_2);
      end
   end
   assign head_valid = valid[rptr];
   assign head_addr = addr[rptr];
   assign head_data = data[rptr];
   assign full = level[PW];
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges the ALU path (A, priority) and the buffered multi-cycle path (B)
// into the register file write port, enforcing write-after-write order.
module writeback_arbiter import writeback_arbiter_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH = 4
) (
   input logic clk,
   input logic arst_n,
   writeback_arbiter_if.slave bus
);
   logic a_issue, push, push_valid, pop, head_valid, full, match_1, match_2;
   reg_addr_t head_addr;
   logic [DATA_W-1:0] head_data;
   logic [$clog2(DEPTH):0] level;
   assign a_issue = bus.a_valid && bus.a_waddr != REG_ZERO;
   assign push = bus.b_valid && !full && bus.b_waddr != REG_ZERO;
   // B is older than a simultaneous A to the same register, so it lands already squashed
   assign push_valid = !(a_issue && bus.a_waddr == bus.b_waddr);
   assign pop = level != '0 && !(head_valid && a_issue);
   wb_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .arst_n(arst_n),
      .push(push),
      .push_valid(push_valid),
      .push_addr(bus.b_waddr),
      .push_data(bus.b_wdata),
      .pop(pop),
      .squash(a_issue),
      .squash_addr(bus.a_waddr),
      .query_1(bus.pend_raddr_1),
      .query_2(bus.pend_raddr_2),
      .head_valid(head_valid),
      .head_addr(head_addr),
      .head_data(head_data),
      .match_1(match_1),
      .match_2(match_2),
      .level(level),
      .full(full)
   );
   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) begin
         bus.reg_write <= 1'b0;
         bus.waddr <= REG_ZERO;
         bus.wdata <= '0;
      end else begin
         bus.reg_write <= a_issue || head_valid;
         if (a_issue) begin
            bus.waddr <= bus.a_waddr;
            bus.wdata <= bus.a_wdata;
         end else if (head_valid) begin
            bus.waddr <= head_addr;
            bus.wdata <= head_data;
         end
      end
   // the register file has no bypass, so the write in progress still counts as pending
   assign bus.pend_1 = bus.pend_raddr_1 != REG_ZERO &&
                       (match_1 || (bus.reg_write && bus.waddr == bus.pend_raddr_1));
   assign bus.pend_2 = bus.pend_raddr_2 != REG_ZERO &&
                       (match_2 || (bus.reg_write && bus.waddr == bus.pend_raddr_2));
   assign bus.b_ready = !full;
   assign bus.fifo_level = level;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed and random stimulus against a queue-based model of the
// writeback rules (priority, WAW squash, address-0 drop, pending flags).
module tb_writeback_arbiter;
   import writeback_arbiter_pkg::*;
   localparam int DW = 16;
   localparam int DEPTH = 4;
   logic clk = 1'b0;
   logic arst_n = 1'b0;
   always #5 clk = ~clk;
   writeback_arbiter_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();
   writeback_arbiter #(.DATA_W(DW), .DEPTH(DEPTH)) dut (.clk(clk), .arst_n(arst_n), .bus(bus));
   typedef struct {bit v; bit [4:0] a; bit [15:0] d;} ent_t;
   ent_t mq[$];
   bit m_rw;
   bit [4:0] m_wa;
   bit [15:0] m_wd;
   int n_vec = 0;
   int n_err = 0;
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic bit exp_pend(bit [4:0] r);
      if (r == 0) return 1'b0;
      if (m_rw && m_wa == r) return 1'b1;
      foreach (mq[i]) if (mq[i].v && mq[i].a == r) return 1'b1;
      return 1'b0;
   endfunction
   task automatic model_edge();
      bit ai, ready;
      ent_t e;
      ai = bus.a_valid && bus.a_waddr != 0;
      ready = mq.size() < DEPTH;
      if (ai) begin
         m_rw = 1'b1;
         m_wa = bus.a_waddr;
         m_wd = bus.a_wdata;
         if (mq.size() > 0 && !mq[0].v) void'(mq.pop_front());
      end else if (mq.size() > 0 && mq[0].v) begin
         m_rw = 1'b1;
         m_wa = mq[0].a;
         m_wd = mq[0].d;
         void'(mq.pop_front());
      end else begin
         m_rw = 1'b0;
         if (mq.size() > 0) void'(mq.pop_front());
      end
      if (ai) foreach (mq[i]) if (mq[i].a == bus.a_waddr) mq[i].v = 1'b0;
      if (bus.b_valid && ready && bus.b_waddr != 0) begin
         e.v = !(ai && bus.a_waddr == bus.b_waddr);
         e.a = bus.b_waddr;
         e.d = bus.b_wdata;
         mq.push_back(e);
      end
   endtask
   task automatic cycle();
      #4;
      chk("b_ready", 32'(bus.b_ready), 32'(mq.size() < DEPTH));
      chk("fifo_level", 32'(bus.fifo_level), 32'(mq.size()));
      chk("pend_1", 32'(bus.pend_1), 32'(exp_pend(bus.pend_raddr_1)));
      chk("pend_2", 32'(bus.pend_2), 32'(exp_pend(bus.pend_raddr_2)));
      @(posedge clk);
      model_edge();
      #1;
      chk("reg_write", 32'(bus.reg_write), 32'(m_rw));
      chk("waddr", 32'(bus.waddr), 32'(m_wa));
      chk("wdata", 32'(bus.wdata), 32'(m_wd));
   endtask
   task automatic drive(bit av, bit [4:0] aa, bit [15:0] ad, bit bv, bit [4:0] ba, bit [15:0] bd,
                        bit [4:0] p1);
      bus.a_valid = av;
      bus.a_waddr = aa;
      bus.a_wdata = ad;
      bus.b_valid = bv;
      bus.b_waddr = ba;
      bus.b_wdata = bd;
      bus.pend_raddr_1 = p1;
      bus.pend_raddr_2 = 5'($urandom_range(0, 7));
      cycle();
   endtask
   task automatic idle(bit [4:0] p1);
      drive(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0, p1);
   endtask
   task automatic chk_reset_state(string tag);
      chk({tag, "_rw"}, 32'(bus.reg_write), 32'd0);
      chk({tag, "_waddr"}, 32'(bus.waddr), 32'd0);
      chk({tag, "_wdata"}, 32'(bus.wdata), 32'd0);
      chk({tag, "_level"}, 32'(bus.fifo_level), 32'd0);
      chk({tag, "_ready"}, 32'(bus.b_ready), 32'd1);
   endtask
   initial begin
      bus.a_valid = 1'b0;
      bus.a_waddr = '0;
      bus.a_wdata = '0;
      bus.b_valid = 1'b0;
      bus.b_waddr = '0;
      bus.b_wdata = '0;
      bus.pend_raddr_1 = '0;
      bus.pend_raddr_2 = '0;
      #2;
      chk_reset_state("reset");
      @(posedge clk);
      #1 arst_n = 1'b1;
      drive(1'b1, 5'd5, 16'h1234, 1'b0, 5'd0, 16'h0, 5'd5);
      chk("a_only_waddr", 32'(bus.waddr), 32'd5);
      chk("a_only_wdata", 32'(bus.wdata), 32'h1234);
      drive(1'b1, 5'd0, 16'h5555, 1'b0, 5'd0, 16'h0, 5'd0);
      chk("a_zero_rw", 32'(bus.reg_write), 32'd0);
      chk("a_zero_hold", 32'(bus.wdata), 32'h1234);
      for (int i = 1; i <= 4; i++)
         drive(1'b1, 5'd9, 16'hA000 + 16'(i), 1'b1, 5'(i), 16'hB000 + 16'(i), 5'd3);
      chk("fill_ready", 32'(bus.b_ready), 32'd0);
      chk("fill_level", 32'(bus.fifo_level), 32'd4);
      for (int i = 1; i <= 4; i++) begin
         idle(5'd3);
         chk("drain_waddr", 32'(bus.waddr), 32'(i));
         chk("drain_wdata", 32'(bus.wdata), 32'hB000 + 32'(i));
      end
      drive(1'b0, 5'd0, 16'h0, 1'b1, 5'd7, 16'hBBBB, 5'd7);
      drive(1'b1, 5'd7, 16'hAAAA, 1'b0, 5'd0, 16'h0, 5'd7);
      chk("squash_wdata", 32'(bus.wdata), 32'hAAAA);
      idle(5'd7);
      chk("squash_no_write", 32'(bus.reg_write), 32'd0);
      drive(1'b1, 5'd7, 16'hAAA1, 1'b1, 5'd7, 16'hBBB1, 5'd7);
      chk("same_cycle_wdata", 32'(bus.wdata), 32'hAAA1);
      idle(5'd7);
      chk("same_cycle_no_write", 32'(bus.reg_write), 32'd0);
      drive(1'b0, 5'd0, 16'h0, 1'b1, 5'd3, 16'h3333, 5'd3);
      chk("pend_queued", 32'(bus.pend_1), 32'd1);
      idle(5'd3);
      chk("pend_issuing", 32'(bus.pend_1), 32'd1);
      idle(5'd3);
      chk("pend_clear", 32'(bus.pend_1), 32'd0);
      for (int i = 0; i < 4; i++)
         drive(1'b1, 5'd9, 16'h9999, 1'b1, 5'd10 + 5'(i), 16'hC000 + 16'(i), 5'd10);
      for (int i = 0; i < 6; i++)
         drive(1'b0, 5'd0, 16'h0, 1'b1, 5'd20 + 5'(i), 16'hD000 + 16'(i), 5'd20);
      for (int i = 0; i < 6; i++) idle(5'd0);
      for (int i = 0; i < 3; i++)
         drive(1'b1, 5'd9, 16'h9999, 1'b1, 5'd1 + 5'(i), 16'hE000 + 16'(i), 5'd1);
      arst_n = 1'b0;
      #2;
      chk_reset_state("mid_reset");
      mq.delete();
      m_rw = 1'b0;
      m_wa = '0;
      m_wd = '0;
      arst_n = 1'b1;
      for (int i = 0; i < 3; i++) idle(5'd1);
      repeat (600)
         drive(1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), 16'($urandom),
               1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 16'($urandom),
               5'($urandom_range(0, 7)));
      for (int i = 0; i < 6; i++) idle(5'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
